// File: rtl/qdec_ctx_init_mc_pkg.sv
// Shared types, constants and arithmetic for the CABAC context-model initialiser.
//   t_state_init_mc     : sequencing FSM states
//   QP_MAX              : upper clip for SliceQpY
//   ctx_init_value_tbl  : initValue lookup indexed by (initType, ctxIdx)
//   ctx_pre_state       : clipped preCtxState from (initValue, clipped QP)
package qdec_cabac_package;

   localparam int QP_MAX      = 51;
   localparam int NUM_CTX_DEF = 567;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } t_state_init_mc;

   // initValue table for the three initTypes. The contents are produced
   // procedurally from (initType, ctxIdx); replacing the body with literal
   // table data leaves every caller unchanged. 154 (the neutral value) is
   // kept frequent, as in real context tables.
   function automatic logic [7:0] ctx_init_value_tbl(input logic [1:0] init_type,
                                                     input int         idx);
      logic [15:0] h;
      h = 16'(idx * 40503 + int'(init_type) * 12345 + 23130);
      h = h ^ (h >> 7);
      if (h[3:1] == 3'd0) return 8'd154;
      return h[15:8] ^ h[7:0];
   endfunction

   // preCtxState = Clip3(1, 126, ((m * qp) >>> 4) + n); >>> floors negatives.
   function automatic logic [6:0] ctx_pre_state(input logic [7:0] iv,
                                                input logic [5:0] qp);
      logic signed [15:0] slope;
      logic signed [15:0] off;
      logic signed [15:0] m;
      logic signed [15:0] n;
      logic signed [15:0] prod;
      logic signed [15:0] pre;
      slope = signed'({12'd0, iv[7:4]});
      off   = signed'({12'd0, iv[3:0]});
      m     = slope * 16'sd5 - 16'sd45;
      n     = (off <<< 3) - 16'sd16;
      prod  = m * signed'({10'd0, qp});
      pre   = (prod >>> 4) + n;
      if (pre < 16'sd1) begin
         pre = 16'sd1;
      end else if (pre > 16'sd126) begin
         pre = 16'sd126;
      end
      return pre[6:0];
   endfunction

endpackage

// File: rtl/qdec_ctx_init_mc_lane.sv
// One lane of context-state computation (purely combinational).
//   iv_i     [7:0] : initValue of the context
//   qpc_i    [5:0] : slice QP, already clipped to 0..51
//   state_o  [6:0] : {pStateIdx[5:0], valMps}
module qdec_ctx_init_lane
   import qdec_cabac_package::*;
(
   input  logic [7:0] iv_i,
   input  logic [5:0] qpc_i,
   output logic [6:0] state_o
);

   logic [6:0] pre;
   logic       val_mps;
   logic [6:0] pstate;

   always_comb begin
      pre     = ctx_pre_state(iv_i, qpc_i);
      val_mps = (pre > 7'd63);
      pstate  = val_mps ? (pre - 7'd64) : (7'd63 - pre);
      state_o = {pstate[5:0], val_mps};
   end

endmodule

// File: rtl/qdec_ctx_init_mc.sv
// CABAC context-model initialiser: on a start pulse walks all NUM_CTX contexts
// and writes LANES context states per beat into context memory, honouring
// write backpressure.
//   clk, rst (sync, active-high)
//   ctx_init_start, init_type, qp : request and slice parameters (sampled in IDLE)
//   ctx_init_ready                : memory accepts the current beat
//   ctx_init_addr/wdata/wmask/we  : write beat (transfer on we & ready)
//   ctx_init_busy, ctx_init_done_intr : status
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; pipeline empty
// ST_SCAN  | issuing beat indices 0..NBEAT-1 into the pipeline
// ST_DRAIN | all beats issued; waiting for the pipeline to empty
// ST_DONE  | one-cycle completion pulse, back to IDLE
module qdec_ctx_init_mc
   import qdec_cabac_package::*;
#(
   parameter int NUM_CTX = 567,
   parameter int LANES   = 4,
   parameter int AW      = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ctx_init_start,
   input  logic [1:0]           init_type,
   input  logic [5:0]           qp,
   input  logic                 ctx_init_ready,
   output logic [AW-1:0]        ctx_init_addr,
   output logic [LANES*7-1:0]   ctx_init_wdata,
   output logic [LANES-1:0]     ctx_init_wmask,
   output logic                 ctx_init_we,
   output logic                 ctx_init_busy,
   output logic                 ctx_init_done_intr
);

   localparam int NBEAT = (NUM_CTX + LANES - 1) / LANES;

   t_state_init_mc     state_q, state_d;
   logic [AW-1:0]      cnt_q, cnt_d;
   logic [5:0]         qpc_q, qpc_d;
   logic [1:0]         itype_q, itype_d;

   logic               s0_vld_q, s0_vld_d;
   logic [AW-1:0]      s0_beat_q, s0_beat_d;
   logic [AW-1:0]      s0_addr;

   logic               s1_vld_q;
   logic [AW-1:0]      s1_addr_q;
   logic [7:0]         s1_iv_q [LANES];
   logic [7:0]         s1_iv_d [LANES];
   logic [LANES-1:0]   s1_mask_q, s1_mask_d;

   logic               s2_vld_q;
   logic [AW-1:0]      s2_addr_q;
   logic [LANES*7-1:0] s2_data_q, s2_data_d;
   logic [LANES-1:0]   s2_mask_q;

   logic [6:0]         lane_state [LANES];
   logic               en;

   // Whole pipeline (counter included) freezes while a beat is refused.
   assign en = ~s2_vld_q | ctx_init_ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      qpc_d     = qpc_q;
      itype_d   = itype_q;
      s0_vld_d  = s0_vld_q;
      s0_beat_d = s0_beat_q;
      if (en) begin
         s0_vld_d = 1'b0;
      end
      case (state_q)
         ST_IDLE: begin
            if (ctx_init_start) begin
               qpc_d   = (int'(qp) > QP_MAX) ? 6'(QP_MAX) : qp;
               itype_d = (init_type == 2'd3) ? 2'd0 : init_type;
               cnt_d   = '0;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (en) begin
               s0_vld_d  = 1'b1;
               s0_beat_d = cnt_q;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == AW'(NBEAT - 1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // S0 is included so a single-beat walk cannot finish early.
            if (!s0_vld_q && !s1_vld_q && !s2_vld_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign s0_addr = AW'(int'(s0_beat_q) * LANES);

   always_comb begin
      s1_mask_d = '0;
      for (int l = 0; l < LANES; l++) begin
         s1_iv_d[l] = '0;
         if (int'(s0_addr) + l < NUM_CTX) begin
            s1_mask_d[l] = 1'b1;
            s1_iv_d[l]   = ctx_init_value_tbl(itype_q, int'(s0_addr) + l);
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      qdec_ctx_init_lane u_lane (
         .iv_i    (s1_iv_q[g]),
         .qpc_i   (qpc_q),
         .state_o (lane_state[g])
      );
   end

   // Lanes past the last context are forced to zero data.
   always_comb begin
      s2_data_d = '0;
      for (int l = 0; l < LANES; l++) begin
         if (s1_mask_q[l]) begin
            s2_data_d[7*l +: 7] = lane_state[l];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         qpc_q     <= '0;
         itype_q   <= '0;
         s0_vld_q  <= 1'b0;
         s0_beat_q <= '0;
         s1_vld_q  <= 1'b0;
         s1_addr_q <= '0;
         s1_mask_q <= '0;
         for (int l = 0; l < LANES; l++) begin
            s1_iv_q[l] <= '0;
         end
         s2_vld_q  <= 1'b0;
         s2_addr_q <= '0;
         s2_data_q <= '0;
         s2_mask_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         qpc_q     <= qpc_d;
         itype_q   <= itype_d;
         s0_vld_q  <= s0_vld_d;
         s0_beat_q <= s0_beat_d;
         if (en) begin
            s1_vld_q  <= s0_vld_q;
            s1_addr_q <= s0_addr;
            s1_mask_q <= s1_mask_d;
            for (int l = 0; l < LANES; l++) begin
               s1_iv_q[l] <= s1_iv_d[l];
            end
            s2_vld_q  <= s1_vld_q;
            s2_addr_q <= s1_addr_q;
            s2_data_q <= s2_data_d;
            s2_mask_q <= s1_mask_q;
         end
      end
   end

   assign ctx_init_addr      = s2_addr_q;
   assign ctx_init_wdata     = s2_data_q;
   assign ctx_init_wmask     = s2_mask_q;
   assign ctx_init_we        = s2_vld_q;
   assign ctx_init_busy      = (state_q != ST_IDLE);
   assign ctx_init_done_intr = (state_q == ST_DONE);

endmodule

// File: tb/tb_qdec_ctx_init_mc.sv
module tb_qdec_ctx_init_mc;
   import qdec_cabac_package::*;

   localparam int NUM_CTX = 567;
   localparam int LANES   = 4;
   localparam int AW      = 10;
   localparam int NBEAT   = (NUM_CTX + LANES - 1) / LANES;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [1:0]           itype;
   logic [5:0]           qp;
   logic                 ready;
   logic [AW-1:0]        addr;
   logic [LANES*7-1:0]   wdata;
   logic [LANES-1:0]     wmask;
   logic                 we;
   logic                 busy;
   logic                 done;

   logic [7:0]           lane_iv;
   logic [5:0]           lane_qpc;
   logic [6:0]           lane_state;

   int n_chk = 0;
   int n_err = 0;

   logic [AW-1:0]        exp_addr [$];
   logic [LANES*7-1:0]   exp_data [$];
   logic [LANES-1:0]     exp_mask [$];

   always #5 clk = ~clk;

   qdec_ctx_init_mc #(.NUM_CTX(NUM_CTX), .LANES(LANES), .AW(AW)) u_dut (
      .clk                (clk),
      .rst                (rst),
      .ctx_init_start     (start),
      .init_type          (itype),
      .qp                 (qp),
      .ctx_init_ready     (ready),
      .ctx_init_addr      (addr),
      .ctx_init_wdata     (wdata),
      .ctx_init_wmask     (wmask),
      .ctx_init_we        (we),
      .ctx_init_busy      (busy),
      .ctx_init_done_intr (done)
   );

   qdec_ctx_init_lane u_lane (
      .iv_i    (lane_iv),
      .qpc_i   (lane_qpc),
      .state_o (lane_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: integer arithmetic with explicit floor division.
   function automatic logic [6:0] ref_state(input int iv, input int qpc);
      int slope, off, m, n, prod, q, pre, mps, ps;
      slope = iv / 16;
      off   = iv % 16;
      m     = slope * 5 - 45;
      n     = off * 8 - 16;
      prod  = m * qpc;
      q     = (prod >= 0) ? prod / 16 : -((-prod + 15) / 16);
      pre   = q + n;
      if (pre < 1)   pre = 1;
      if (pre > 126) pre = 126;
      mps = (pre > 63) ? 1 : 0;
      ps  = (mps == 1) ? pre - 64 : 63 - pre;
      return 7'(ps * 2 + mps);
   endfunction

   task automatic build_expected(input int qpc, input int t);
      logic [LANES*7-1:0] d;
      logic [LANES-1:0]   mk;
      int a;
      exp_addr.delete();
      exp_data.delete();
      exp_mask.delete();
      for (int b = 0; b < NBEAT; b++) begin
         a  = b * LANES;
         d  = '0;
         mk = '0;
         for (int l = 0; l < LANES; l++) begin
            if (a + l < NUM_CTX) begin
               mk[l] = 1'b1;
               d[7*l +: 7] = ref_state(int'(ctx_init_value_tbl(2'(t), a + l)), qpc);
            end
         end
         exp_addr.push_back(AW'(a));
         exp_data.push_back(d);
         exp_mask.push_back(mk);
      end
   endtask

   task automatic run_txn(input int qp_v, input int typ_v, input int low_pct,
                          input int abort_beat, input bit extra_start);
      int qpc, t, cyc, beats, a_last;
      bit done_seen, prev_stall, saw_done;
      logic [AW-1:0]      h_addr, last_addr;
      logic [LANES*7-1:0] h_data;
      logic [LANES-1:0]   h_mask, last_mask, lm;
      qpc = (qp_v > 51) ? 51 : qp_v;
      t   = (typ_v == 3) ? 0 : typ_v;
      build_expected(qpc, t);
      @(negedge clk);
      start = 1'b1;
      qp    = 6'(qp_v);
      itype = 2'(typ_v);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      cyc = 0; beats = 0; done_seen = 0; prev_stall = 0;
      last_addr = '0; last_mask = '0; h_addr = '0; h_data = '0; h_mask = '0;
      while (!done_seen && cyc < 3000) begin
         if (prev_stall) begin
            chk("hold_we",   32'(we),    32'd1);
            chk("hold_addr", 32'(addr),  32'(h_addr));
            chk("hold_data", 32'(wdata), 32'(h_data));
            chk("hold_mask", 32'(wmask), 32'(h_mask));
         end
         ready = (low_pct > 0 && $urandom_range(99) < low_pct) ? 1'b0 : 1'b1;
         start = extra_start && (cyc == 20);
         if (we && ready) begin
            if (exp_addr.size() == 0) begin
               chk("extra_beat", 32'd1, 32'd0);
            end else begin
               chk("beat_addr", 32'(addr),  32'(exp_addr.pop_front()));
               chk("beat_data", 32'(wdata), 32'(exp_data.pop_front()));
               chk("beat_mask", 32'(wmask), 32'(exp_mask.pop_front()));
            end
            beats++;
            last_mask = wmask;
            last_addr = addr;
         end
         prev_stall = we && !ready;
         h_addr = addr; h_data = wdata; h_mask = wmask;
         if (abort_beat > 0 && beats == abort_beat) begin
            rst = 1'b1;
            @(negedge clk);
            chk("abort_we",   32'(we),   32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            rst   = 1'b0;
            start = 1'b0;
            saw_done = 0;
            repeat (10) begin
               @(negedge clk);
               if (done || we) saw_done = 1;
            end
            chk("abort_quiet", 32'(saw_done), 32'd0);
            return;
         end
         @(negedge clk);
         cyc++;
         if (done) done_seen = 1;
      end
      start = 1'b0;
      chk("done_seen", 32'(done_seen), 32'd1);
      if (low_pct == 0) chk("done_latency", 32'(cyc), 32'(NBEAT + 4));
      chk("beat_count", 32'(beats), 32'(NBEAT));
      chk("queue_empty", 32'(exp_addr.size()), 32'd0);
      a_last = (NBEAT - 1) * LANES;
      lm = '0;
      for (int l = 0; l < LANES; l++) if (a_last + l < NUM_CTX) lm[l] = 1'b1;
      chk("last_addr", 32'(last_addr), 32'(a_last));
      chk("last_mask", 32'(last_mask), 32'(lm));
      chk("busy_at_done", 32'(busy), 32'd1);
      chk("we_at_done", 32'(we), 32'd0);
      if (extra_start) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_clear", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      chk("idle_we", 32'(we), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; itype = '0; qp = '0; ready = 1'b1;
      lane_iv = '0; lane_qpc = '0;
      repeat (3) @(negedge clk);
      chk("rst_we",    32'(we),    32'd0);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_done",  32'(done),  32'd0);
      chk("rst_addr",  32'(addr),  32'd0);
      chk("rst_wdata", 32'(wdata), 32'd0);
      chk("rst_wmask", 32'(wmask), 32'd0);
      rst = 1'b0;

      lane_iv = 8'd154; lane_qpc = 6'd26; #1;
      chk("lane_154_26", 32'(lane_state), 32'h01);
      lane_iv = 8'd139; lane_qpc = 6'd30; #1;
      chk("lane_139_30", 32'(lane_state), 32'h02);
      lane_iv = 8'd63;  lane_qpc = 6'd51; #1;
      chk("lane_63_51", 32'(lane_state), 32'h6E);
      lane_iv = 8'd255; lane_qpc = 6'd51; #1;
      chk("lane_255_51", 32'(lane_state), 32'h7D);
      for (int i = 0; i < 200; i++) begin
         lane_iv  = 8'($urandom_range(255));
         lane_qpc = 6'($urandom_range(51));
         #1;
         chk("lane_rand", 32'(lane_state), 32'(ref_state(int'(lane_iv), int'(lane_qpc))));
      end

      run_txn(32, 0, 0, 0, 1'b0);
      run_txn(63, 3, 30, 0, 1'b1);
      run_txn(int'($urandom_range(63)), 1, 30, 0, 1'b0);
      run_txn(int'($urandom_range(63)), 2, 0, 0, 1'b1);
      run_txn(int'($urandom_range(63)), int'($urandom_range(3)), 0, 50, 1'b0);
      run_txn(int'($urandom_range(63)), 0, 30, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
